// File: rtl/tracker_row_sequencer_if.sv
// Control and voice-side signals of the tracker row sequencer.
// The master side is the pattern/config logic; the slave side is the sequencer.
interface tracker_row_sequencer_if #(
    parameter int TEMPO_W = 24,
    parameter int FREQ_W  = 32,
    parameter int AW      = 6
);
    logic               start;
    logic               stop;
    logic [TEMPO_W-1:0] tempo_div;
    logic [AW-1:0]      loop_len;
    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [7:0]         wr_data;
    logic [FREQ_W-1:0]  freq_word;
    logic               gate;
    logic               note_on;
    logic [AW-1:0]      row;
    logic               row_strobe;
    logic               busy;

    modport master (
        output start, stop, tempo_div, loop_len, wr_en, wr_addr, wr_data,
        input  freq_word, gate, note_on, row, row_strobe, busy
    );
    modport slave (
        input  start, stop, tempo_div, loop_len, wr_en, wr_addr, wr_data,
        output freq_word, gate, note_on, row, row_strobe, busy
    );
endinterface

// File: rtl/tracker_row_sequencer.sv
// Plays a note pattern row by row at a programmable tempo, driving the DDS
// phase increment plus gate / note-on pulses for the voice path.
module tracker_row_sequencer #(
    parameter int ROWS    = 64,
    parameter int TEMPO_W = 24,
    parameter int FREQ_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst_active_low,
    tracker_row_sequencer_if.slave  bus
);
    localparam int AW = $clog2(ROWS);

    typedef enum logic [1:0] {IDLE, FETCH, APPLY, PLAY} state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      ptr_q, ptr_d;
    logic [AW-1:0]      row_q, row_d;
    logic [TEMPO_W-1:0] cnt_q, cnt_d;
    logic [FREQ_W-1:0]  freq_q, freq_d;
    logic               gate_q, gate_d;
    logic               note_on_q, note_on_d;
    logic               row_strobe_q, row_strobe_d;
    logic               busy_q, busy_d;
    logic [7:0]         entry;

    logic [7:0] mem [ROWS];

    // Pattern storage has no reset; the read below sees pre-write contents on a same-edge write.
    always_ff @(posedge clk) begin
        if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;
    end

    function automatic logic [FREQ_W-1:0] note_freq(input logic [6:0] note);
        logic [3:0]  oct;
        logic [3:0]  semi;
        logic [19:0] base;
        oct  = 4'(note / 7'd12);
        semi = 4'(note % 7'd12);
        case (semi)
            4'd0:    base = 20'd359575;
            4'd1:    base = 20'd380953;
            4'd2:    base = 20'd403601;
            4'd3:    base = 20'd427596;
            4'd4:    base = 20'd453018;
            4'd5:    base = 20'd479951;
            4'd6:    base = 20'd508485;
            4'd7:    base = 20'd538716;
            4'd8:    base = 20'd570743;
            4'd9:    base = 20'd604727;
            4'd10:   base = 20'd640679;
            default: base = 20'd678769;
        endcase
        return {{(FREQ_W-20){1'b0}}, base >> (4'd10 - oct)};
    endfunction

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        row_d        = row_q;
        cnt_d        = cnt_q;
        freq_d       = freq_q;
        gate_d       = gate_q;
        note_on_d    = 1'b0;
        row_strobe_d = 1'b0;
        entry        = mem[ptr_q];

        if (bus.stop) begin
            state_d = IDLE;
            gate_d  = 1'b0;
        end else if (bus.start) begin
            state_d = FETCH;
            ptr_d   = '0;
        end else begin
            case (state_q)
                // Read and decode in one step so the new row sounds on the strobe cycle.
                FETCH: begin
                    state_d      = APPLY;
                    row_d        = ptr_q;
                    row_strobe_d = 1'b1;
                    if (entry[7]) begin
                        freq_d    = note_freq(entry[6:0]);
                        gate_d    = 1'b1;
                        note_on_d = 1'b1;
                    end else if (entry == 8'h00) begin
                        gate_d = 1'b0;
                    end
                end
                // APPLY + (P-2) PLAY cycles + FETCH = P cycles between strobes.
                APPLY: begin
                    state_d = PLAY;
                    cnt_d   = (bus.tempo_div < TEMPO_W'(4)) ? TEMPO_W'(1)
                                                            : bus.tempo_div - TEMPO_W'(3);
                end
                PLAY: begin
                    if (cnt_q == '0) begin
                        state_d = FETCH;
                        ptr_d   = (ptr_q >= bus.loop_len) ? '0 : ptr_q + AW'(1);
                    end else begin
                        cnt_d = cnt_q - TEMPO_W'(1);
                    end
                end
                default: ;
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_active_low) begin
        if (!rst_active_low) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            row_q        <= '0;
            cnt_q        <= '0;
            freq_q       <= '0;
            gate_q       <= 1'b0;
            note_on_q    <= 1'b0;
            row_strobe_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            row_q        <= row_d;
            cnt_q        <= cnt_d;
            freq_q       <= freq_d;
            gate_q       <= gate_d;
            note_on_q    <= note_on_d;
            row_strobe_q <= row_strobe_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.freq_word  = freq_q;
    assign bus.gate       = gate_q;
    assign bus.note_on    = note_on_q;
    assign bus.row        = row_q;
    assign bus.row_strobe = row_strobe_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_tracker_row_sequencer.sv
// Directed bench for tracker_row_sequencer: timing, decode, looping, stop/restart, reset.
module tb_tracker_row_sequencer;
    logic clk = 1'b0;
    logic rst_active_low = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   n;
    int   strobes;

    tracker_row_sequencer_if #(.TEMPO_W(24), .FREQ_W(32), .AW(6)) bus ();

    tracker_row_sequencer #(.ROWS(64), .TEMPO_W(24), .FREQ_W(32)) dut (
        .clk            (clk),
        .rst_active_low (rst_active_low),
        .bus            (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // n = cycles until the next strobe, or -1 if none within max
    task automatic wait_strobe(input int max, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!bus.row_strobe && cyc < max);
        if (!bus.row_strobe) cyc = -1;
    endtask

    task automatic count_strobes(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (bus.row_strobe) cnt++;
        end
    endtask

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        bus.start = 0; bus.stop = 0; bus.tempo_div = 24'd10; bus.loop_len = 6'd1;
        bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0;
        tick(); tick();
        chk("rst_freq", bus.freq_word, 0);
        chk("rst_gate", 32'(bus.gate), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_strobe", 32'(bus.row_strobe), 0);
        chk("rst_row", 32'(bus.row), 0);
        rst_active_low = 1'b1;
        tick();

        // basic two-row loop, P=10
        wr(6'd0, 8'hA4);
        wr(6'd1, 8'hC5);
        pulse_start();
        chk("t2_busy", 32'(bus.busy), 1);
        chk("t2_no_strobe_n1", 32'(bus.row_strobe), 0);
        tick();
        chk("t2_strobe_n2", 32'(bus.row_strobe), 1);
        chk("t2_freq36", bus.freq_word, 2809);
        chk("t2_gate", 32'(bus.gate), 1);
        chk("t2_note_on", 32'(bus.note_on), 1);
        tick();
        chk("t2_note_on_1cyc", 32'(bus.note_on), 0);
        wait_strobe(30, n);
        chk("t2_period_a", n, 9);
        chk("t2_freq69", bus.freq_word, 18897);
        chk("t2_row1", 32'(bus.row), 1);
        wait_strobe(30, n);
        chk("t2_period_b", n, 10);
        chk("t2_wrap_row0", 32'(bus.row), 0);
        chk("t2_freq36_again", bus.freq_word, 2809);

        // tempo below minimum, then change mid-row
        bus.tempo_div = 24'd2;
        wait_strobe(30, n);
        chk("t3_min_period_a", n, 4);
        wait_strobe(30, n);
        chk("t3_min_period_b", n, 4);
        tick();
        bus.tempo_div = 24'd20;
        wait_strobe(30, n);
        chk("t3_old_period_kept", n, 3);
        wait_strobe(30, n);
        chk("t3_new_period", n, 20);
        chk("t3_row", 32'(bus.row), 0);

        // stop during PLAY
        tick(); tick();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        chk("t5_stop_busy", 32'(bus.busy), 0);
        chk("t5_stop_gate", 32'(bus.gate), 0);
        chk("t5_stop_freq_held", bus.freq_word, 2809);
        count_strobes(25, strobes);
        chk("t5_stop_no_strobes", strobes, 0);
        bus.start = 1'b1; bus.stop = 1'b1;
        tick();
        bus.start = 1'b0; bus.stop = 1'b0;
        chk("t5_start_stop_busy", 32'(bus.busy), 0);
        count_strobes(10, strobes);
        chk("t5_start_stop_idle", strobes, 0);

        // note, off, hold, hold
        wr(6'd0, 8'hBC);
        wr(6'd1, 8'h00);
        wr(6'd2, 8'h55);
        wr(6'd3, 8'h37);
        bus.loop_len = 6'd3; bus.tempo_div = 24'd4;
        pulse_start();
        wait_strobe(5, n);
        chk("t4_first", n, 1);
        chk("t4_r0_gate", 32'(bus.gate), 1);
        chk("t4_r0_note_on", 32'(bus.note_on), 1);
        chk("t4_r0_freq", bus.freq_word, 11236);
        wait_strobe(10, n);
        chk("t4_r1_gate", 32'(bus.gate), 0);
        chk("t4_r1_note_on", 32'(bus.note_on), 0);
        chk("t4_r1_freq", bus.freq_word, 11236);
        wait_strobe(10, n);
        chk("t4_r2_row", 32'(bus.row), 2);
        chk("t4_r2_gate", 32'(bus.gate), 0);
        chk("t4_r2_note_on", 32'(bus.note_on), 0);
        wait_strobe(10, n);
        chk("t4_r3_row", 32'(bus.row), 3);
        chk("t4_r3_freq", bus.freq_word, 11236);
        wait_strobe(10, n);
        chk("t4_wrap_row", 32'(bus.row), 0);
        chk("t4_wrap_note_on", 32'(bus.note_on), 1);

        // lower loop_len below current row
        wait_strobe(10, n);
        wait_strobe(10, n);
        chk("t4_at_row2", 32'(bus.row), 2);
        bus.loop_len = 6'd1;
        wait_strobe(10, n);
        chk("t4_shrink_wrap", 32'(bus.row), 0);
        bus.loop_len = 6'd3;

        // restart while busy: row/gate held until the new first row applies
        wait_strobe(10, n);
        chk("t4_row1_before_restart", 32'(bus.row), 1);
        tick();
        pulse_start();
        chk("t4_restart_busy", 32'(bus.busy), 1);
        chk("t4_restart_row_held", 32'(bus.row), 1);
        chk("t4_restart_gate_held", 32'(bus.gate), 0);
        wait_strobe(10, n);
        chk("t4_restart_latency", n, 1);
        chk("t4_restart_row0", 32'(bus.row), 0);
        chk("t4_restart_gate", 32'(bus.gate), 1);

        // extreme notes and read-before-write on the fetched row
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        wr(6'd0, 8'hFF);
        wr(6'd1, 8'h80);
        bus.loop_len = 6'd1;
        pulse_start();
        wait_strobe(5, n);
        chk("t6_note127", bus.freq_word, 538716);
        tick(); tick(); tick();
        bus.wr_en = 1'b1; bus.wr_addr = 6'd1; bus.wr_data = 8'h90;
        tick();
        bus.wr_en = 1'b0;
        chk("t6_strobe_row1", 32'(bus.row_strobe), 1);
        chk("t6_old_data_note0", bus.freq_word, 351);
        chk("t6_row1", 32'(bus.row), 1);
        wait_strobe(10, n);
        chk("t6_back_row0", bus.freq_word, 538716);
        wait_strobe(10, n);
        chk("t6_new_data_note16", bus.freq_word, 884);

        // async reset mid-PLAY
        tick();
        rst_active_low = 1'b0;
        #1;
        chk("t1_rst_freq", bus.freq_word, 0);
        chk("t1_rst_gate", 32'(bus.gate), 0);
        chk("t1_rst_note_on", 32'(bus.note_on), 0);
        chk("t1_rst_row", 32'(bus.row), 0);
        chk("t1_rst_strobe", 32'(bus.row_strobe), 0);
        chk("t1_rst_busy", 32'(bus.busy), 0);
        tick();
        rst_active_low = 1'b1;
        tick();
        chk("t1_busy_after_release", 32'(bus.busy), 0);
        count_strobes(10, strobes);
        chk("t1_no_strobes_after_reset", strobes, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
